// File: rtl/wgt_rot_rf_bank_if.sv
// rtl/wgt_rot_rf_bank_if.sv - load/rotate bus of the weight rotation register-file bank
interface wgt_rot_rf_bank_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int BUFFER_COUNT = 16,
   parameter int DEPTH_W      = 5
);
   logic [DEPTH_W-1:0]                 cfg_depth;
   logic                               load_start;
   logic                               load_valid;
   logic [BUFFER_COUNT*DATA_WIDTH-1:0] load_data;
   logic                               load_done;
   logic                               ready;
   logic [BUFFER_COUNT-1:0]            shift_en;
   logic [BUFFER_COUNT*DATA_WIDTH-1:0] data_out;
   logic [BUFFER_COUNT-1:0]            wrap;

   modport master (
      output cfg_depth, load_start, load_valid, load_data, shift_en,
      input  load_done, ready, data_out, wrap
   );

   modport slave (
      input  cfg_depth, load_start, load_valid, load_data, shift_en,
      output load_done, ready, data_out, wrap
   );
endinterface

// File: rtl/wgt_rot_rf_bank.sv
// rtl/wgt_rot_rf_bank.sv - per-channel circular weight register files with burst load and rotation
module wgt_rot_rf_bank #(
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_DEPTH    = 27,
   parameter int BUFFER_COUNT = 16,
   parameter int DEPTH_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   wgt_rot_rf_bank_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

   localparam logic [DEPTH_W-1:0] MAXD = DEPTH_W'(MAX_DEPTH);
   localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);

   state_t                 state_q;
   logic [DEPTH_W-1:0]     cnt_q;
   logic [DEPTH_W-1:0]     depth_q;
   logic [DEPTH_W-1:0]     depth_d;
   logic [DEPTH_W-1:0]     head_q   [BUFFER_COUNT];
   logic [DEPTH_W-1:0]     head_d   [BUFFER_COUNT];
   logic [DATA_WIDTH-1:0]  data_q   [BUFFER_COUNT];
   logic [DATA_WIDTH-1:0]  word_in  [BUFFER_COUNT];
   logic [DATA_WIDTH-1:0]  mem_q    [BUFFER_COUNT][MAX_DEPTH];
   logic [BUFFER_COUNT-1:0] wrap_q;
   logic                   beat;
   logic                   last_beat;

   always_comb begin
      // A beat arriving together with load_start belongs to the abandoned burst.
      beat      = (state_q == S_LOAD) && bus.load_valid && !bus.load_start;
      last_beat = beat && (cnt_q == depth_q - ONE);
      depth_d   = ((bus.cfg_depth == '0) || (bus.cfg_depth > MAXD)) ? MAXD : bus.cfg_depth;
      for (int i = 0; i < BUFFER_COUNT; i++) begin
         word_in[i] = bus.load_data[i*DATA_WIDTH +: DATA_WIDTH];
         head_d[i]  = (head_q[i] == depth_q - ONE) ? '0 : head_q[i] + ONE;
      end
   end

   assign bus.load_done = last_beat;
   assign bus.ready     = (state_q == S_READY);
   assign bus.wrap      = wrap_q;

   for (genvar g = 0; g < BUFFER_COUNT; g++) begin : g_out
      assign bus.data_out[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         depth_q <= '0;
         wrap_q  <= '0;
         for (int i = 0; i < BUFFER_COUNT; i++) begin
            head_q[i] <= '0;
            data_q[i] <= '0;
            for (int j = 0; j < MAX_DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
         end
      end else begin
         wrap_q <= '0;
         if (bus.load_start) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            depth_q <= depth_d;
            for (int i = 0; i < BUFFER_COUNT; i++) begin
               data_q[i] <= '0;
            end
         end else begin
            case (state_q)
               S_LOAD: begin
                  if (beat) begin
                     cnt_q <= cnt_q + ONE;
                     for (int i = 0; i < BUFFER_COUNT; i++) begin
                        mem_q[i][cnt_q] <= word_in[i];
                     end
                     if (last_beat) begin
                        state_q <= S_READY;
                        cnt_q   <= '0;
                        // With depth 1 the head word is the beat being written right now.
                        for (int i = 0; i < BUFFER_COUNT; i++) begin
                           head_q[i] <= '0;
                           data_q[i] <= (cnt_q == '0) ? word_in[i] : mem_q[i][0];
                        end
                     end
                  end
               end
               S_READY: begin
                  for (int i = 0; i < BUFFER_COUNT; i++) begin
                     if (bus.shift_en[i]) begin
                        head_q[i] <= head_d[i];
                        data_q[i] <= mem_q[i][head_d[i]];
                        wrap_q[i] <= (head_d[i] == '0);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_wgt_rot_rf_bank.sv
// tb/tb_wgt_rot_rf_bank.sv - directed scoreboard bench for wgt_rot_rf_bank
module tb_wgt_rot_rf_bank;
   localparam int DW = 8;
   localparam int BC = 16;
   localparam int VW = BC*DW;

   typedef struct {
      string tag;
      int    kind;
      int    ch;
      logic [7:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];

   wgt_rot_rf_bank_if #(.DATA_WIDTH(DW), .BUFFER_COUNT(BC), .DEPTH_W(5)) bus ();

   wgt_rot_rf_bank #(.DATA_WIDTH(DW), .MAX_DEPTH(27), .BUFFER_COUNT(BC), .DEPTH_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // kind 0: data_out word of channel ch, 1: ready, 2: wrap bit of channel ch
   function automatic logic [7:0] obs(input int kind, input int ch);
      case (kind)
         0:       return bus.data_out[ch*DW +: DW];
         1:       return 8'(bus.ready);
         default: return 8'(bus.wrap[ch]);
      endcase
   endfunction

   function automatic logic [VW-1:0] pat(input int base);
      logic [VW-1:0] v;
      for (int i = 0; i < BC; i++) v[i*DW +: DW] = 8'(i*32 + base);
      return v;
   endfunction

   function automatic logic [VW-1:0] fill(input logic [7:0] w);
      logic [VW-1:0] v;
      for (int i = 0; i < BC; i++) v[i*DW +: DW] = w;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
   endtask

   task automatic push(input string tag, input int kind, input int ch, input logic [7:0] v);
      exp_t e;
      e.tag = tag; e.kind = kind; e.ch = ch; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.tag, obs(e.kind, e.ch), e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic do_start(input logic [4:0] cfg);
      bus.load_start = 1'b1;
      bus.cfg_depth  = cfg;
      bus.load_valid = 1'b0;
      #2 chk("start_load_done", 8'(bus.load_done), 8'h0);
      tick();
      bus.load_start = 1'b0;
      chk("load_ready", obs(1, 0), 8'h0);
      chk("load_data_out", obs(0, 0), 8'h0);
   endtask

   task automatic beat(input logic [VW-1:0] d, input logic exp_done);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      #2 chk("load_done", 8'(bus.load_done), 8'(exp_done));
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic gap();
      bus.load_valid = 1'b0;
      bus.load_data  = fill(8'($urandom_range(0, 255)));
      #2 chk("gap_load_done", 8'(bus.load_done), 8'h0);
      tick();
   endtask

   task automatic load_full(input logic [4:0] cfg, input int base);
      do_start(cfg);
      for (int k = 0; k < 27; k++) begin
         if (k == 26) begin
            push("head_ready", 1, 0, 8'h1);
            push("head_ch0", 0, 0, 8'(base));
            push("head_ch15", 0, 15, 8'(480 + base));
         end
         beat(pat(base + k), k == 26);
      end
   endtask

   initial begin
      bus.cfg_depth  = '0;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.shift_en   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", obs(1, 0), 8'h0);
      chk("rst_data", obs(0, 5), 8'h0);
      chk("rst_wrap", 8'(|bus.wrap), 8'h0);
      chk("rst_load_done", 8'(bus.load_done), 8'h0);
      rst = 1'b0;

      // full-depth load, then rotate channel 3 once round
      load_full(5'd27, 0);
      bus.shift_en = 16'h0008;
      for (int s = 0; s < 27; s++) begin
         push("rot_ch3", 0, 3, 8'(96 + (s + 1) % 27));
         push("rot_wrap3", 2, 3, 8'(s == 26));
         push("rot_ch0_hold", 0, 0, 8'h0);
         tick();
      end
      bus.shift_en = '0;
      push("rot_wrap3_after", 2, 3, 8'h0);
      push("rot_ch3_held", 0, 3, 8'd96);
      tick();

      // out-of-range depth configs fall back to full depth
      load_full(5'd0, 40);
      load_full(5'd31, 70);

      // restart mid-burst; the simultaneous beat must be dropped
      do_start(5'd27);
      for (int k = 0; k < 10; k++) beat(pat(k), 1'b0);
      bus.load_start = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_data  = pat(200);
      #2 chk("restart_load_done", 8'(bus.load_done), 8'h0);
      tick();
      bus.load_start = 1'b0;
      for (int k = 0; k < 27; k++) begin
         if (k == 26) begin
            push("restart_ready", 1, 0, 8'h1);
            push("restart_ch0", 0, 0, 8'd100);
            push("restart_ch2", 0, 2, 8'd164);
         end
         beat(pat(100 + k), k == 26);
      end

      // depth 1: every shift wraps, then reset mid-rotation
      do_start(5'd1);
      push("d1_ready", 1, 0, 8'h1);
      push("d1_head", 0, 4, 8'd9);
      beat(fill(8'd9), 1'b1);
      bus.shift_en = 16'h0001;
      for (int s = 0; s < 3; s++) begin
         push("d1_wrap0", 2, 0, 8'h1);
         push("d1_wrap1", 2, 1, 8'h0);
         push("d1_data", 0, 0, 8'd9);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("arst_data", obs(0, 0), 8'h0);
      chk("arst_ready", obs(1, 0), 8'h0);
      chk("arst_wrap", obs(2, 0), 8'h0);
      tick();
      rst = 1'b0;
      bus.shift_en = '1;
      for (int s = 0; s < 3; s++) begin
         push("post_rst_ready", 1, 0, 8'h0);
         push("post_rst_data", 0, 7, 8'h0);
         push("post_rst_wrap", 2, 7, 8'h0);
         tick();
      end
      bus.shift_en = '0;

      // depth 3 with stalls, then rotate all channels
      do_start(5'd3);
      beat(fill(8'd5), 1'b0);
      gap();
      beat(fill(8'd6), 1'b0);
      gap();
      gap();
      push("d3_ready", 1, 0, 8'h1);
      push("d3_head", 0, 7, 8'd5);
      beat(fill(8'd7), 1'b1);
      bus.shift_en = '1;
      for (int s = 0; s < 6; s++) begin
         push("d3_rot", 0, 0, 8'(5 + (s + 1) % 3));
         push("d3_rot_ch12", 0, 12, 8'(5 + (s + 1) % 3));
         push("d3_wrap", 2, 0, 8'(s % 3 == 2));
         tick();
      end
      bus.shift_en = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/wgt_rot_rf_bank.md
Name: wgt_rot_RF_bank

Overview:
- Parametrised successor to the 16-channel weight shift register-file bank.
- BUFFER_COUNT independent weight channels, each a circular register file of up to MAX_DEPTH words.
- Adds a runtime-configurable active depth for kernel size, a burst-load handshake, and per-channel recirculating rotation, so weights are reused across output tiles without reloading.
- Sits between the weight buffer reader and the systolic array's weight inputs.

Parameters:
- DATA_WIDTH, 8: width of one weight word.
- MAX_DEPTH, 27: physical entries per channel.
- BUFFER_COUNT, 16: number of channels (filters).
- DEPTH_W, 5: width of depth and pointer fields; must satisfy 2^DEPTH_W > MAX_DEPTH.

Ports:
- clk, in, 1: single clock; all logic rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- cfg_depth, in, DEPTH_W: active depth D; sampled only on load_start.
- load_start, in, 1: begin a new load burst.
- load_valid, in, 1: load_data beat valid.
- load_data, in, BUFFER_COUNT*DATA_WIDTH: one word per channel; channel i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- load_done, out, 1: one-cycle pulse when the D-th beat is accepted.
- ready, out, 1: bank is in READY and holds a complete weight set.
- shift_en, in, BUFFER_COUNT: per-channel rotate enable.
- data_out, out, BUFFER_COUNT*DATA_WIDTH: head word of each channel, same packing as load_data.
- wrap, out, BUFFER_COUNT: per-channel one-cycle pulse when that head pointer wraps to 0.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; all storage entries are 0.
  - All head pointers, the load counter and the latched depth are 0.
  - load_done=0, ready=0, wrap=0, data_out=0.
- States:
  - IDLE, LOAD, READY.
  - IDLE -> LOAD on load_start.
  - LOAD -> READY when the D-th beat is accepted.
  - READY -> LOAD on load_start.
  - LOAD -> LOAD on load_start: the burst restarts and the load counter clears.
- Depth latch:
  - On load_start, D_lat = cfg_depth.
  - If cfg_depth is 0 or greater than MAX_DEPTH, D_lat = MAX_DEPTH.
- LOAD:
  - Each cycle with load_valid=1 writes load_data word i into entry cnt of channel i, for all channels, then cnt = cnt+1.
  - When the beat with cnt = D_lat-1 is accepted:
    - load_done pulses in the same cycle.
    - State is READY from the next cycle.
    - All head pointers reset to 0.
  - load_valid=0 stalls the burst and holds cnt.
- Precedence and ignored inputs:
  - load_start and load_valid in the same cycle: load_start wins and that beat is discarded.
  - load_valid outside LOAD is ignored.
  - shift_en outside READY is ignored.
- READY:
  - ready=1.
  - data_out[i] = entry[head_i] of channel i, registered; valid in the first READY cycle.
  - shift_en[i]=1 advances head_i = (head_i+1) mod D_lat; the new word appears on data_out the next cycle.
  - Channels rotate independently; shift_en[i]=0 holds channel i.
- wrap:
  - wrap[i] is asserted in the cycle after a shift that moves head_i from D_lat-1 to 0.
  - With D_lat=1, every shift wraps, so wrap[i] follows shift_en[i] delayed by 1 cycle.
- Storage and outputs during LOAD / IDLE:
  - Storage contents persist across rotation; rotation never modifies stored words.
  - data_out is held at 0 and ready=0 while not in READY.
- Reset mid-LOAD or mid-rotation: immediate return to reset values; a partial burst is lost.
- Entries at index >= D_lat are never read; they may hold stale data.

Test Plan:
- Reset then load D=27, channel i beat k = i*32+k (mod 256) -> load_done pulses on the 27th accepted beat, ready=1 next cycle, data_out ch0=0, ch15=224 (0xE0).
- After that load, hold shift_en[3]=1 for 27 cycles, others 0 -> ch3 outputs 96..122 in order, returns to 96, wrap[3] pulses once; ch0 stays 0.
- cfg_depth=3, load words 5,6,7 on all channels with load_valid gaps -> load_done only after the 3rd valid beat; rotation sequence 5,6,7,5; wrap every 3 shifts.
- cfg_depth=0 and cfg_depth=31 -> both behave as depth 27 (27 beats to load_done).
- load_start in cycle 10 of a 27-beat load, with a simultaneous load_valid -> that beat is dropped, the counter restarts, 27 further beats are needed, and new data appears at head.
- Assert rst during READY mid-rotation -> data_out=0, ready=0, wrap=0 immediately; shift_en is ignored until a new load completes.
